// File: rtl/operand_deco_pkg.sv
// Shared constants and types for the operand decoration scheduler.
// Decoration select encodings, IEEE-754 single constants and output-stage state type.
package operand_deco_pkg;

    localparam logic [1:0] DECO_PASS = 2'b00;
    localparam logic [1:0] DECO_NEG  = 2'b01;
    localparam logic [1:0] DECO_SAT  = 2'b10;
    localparam logic [1:0] DECO_ABS  = 2'b11;

    localparam logic [31:0] FP_ONE      = 32'h3F80_0000;
    localparam int          FP_SIGN_BIT = 31;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/operand_decorate_unit.sv
// Combinational operand decoration: integer pass/negate/saturate/abs and
// float pass/negate/clamp-to-[0,1]/abs on a single 32-bit operand.
module operand_decorate_unit
    import operand_deco_pkg::*;
(
    input  logic        int_float,
    input  logic [1:0]  deco,
    input  logic [31:0] data,
    output logic [31:0] res
);

    logic [31:0] int_neg;
    logic        fp_is_nan;

    assign int_neg   = ~data + 32'd1;
    assign fp_is_nan = (data[30:23] == 8'hFF) && (data[22:0] != 23'd0);

    always_comb begin
        res = data;
        if (!int_float) begin
            case (deco)
                DECO_PASS: res = data;
                DECO_NEG:  res = int_neg;
                DECO_SAT:  res = (data != 32'd0) ? 32'd1 : 32'd0;
                DECO_ABS:  res = data[FP_SIGN_BIT] ? int_neg : data;
                default:   res = data;
            endcase
        end else begin
            case (deco)
                DECO_PASS: res = data;
                DECO_NEG:  res = {~data[FP_SIGN_BIT], data[30:0]};
                DECO_ABS:  res = {1'b0, data[30:0]};
                DECO_SAT: begin
                    // Positive floats order like unsigned ints, so +inf lands above FP_ONE.
                    if (fp_is_nan || data[FP_SIGN_BIT]) res = 32'd0;
                    else if (data > FP_ONE)             res = FP_ONE;
                    else                                res = data;
                end
                default:   res = data;
            endcase
        end
    end

endmodule

// File: rtl/operand_deco_scheduler.sv
// Round-robin sharing of one operand decoration unit between NUM_REQ requesters,
// with a one-entry registered output stage under valid/ready backpressure.
//
//   state     | meaning
//   ----------+--------------------------------------------
//   OUT_EMPTY | no result held, out_valid=0
//   OUT_FULL  | result held in output register, out_valid=1
module operand_deco_scheduler
    import operand_deco_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 5,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_int_float,
    input  logic [2*NUM_REQ-1:0]     req_deco,
    input  logic [32*NUM_REQ-1:0]    req_data,
    input  logic [TAG_W*NUM_REQ-1:0] req_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [ID_W-1:0]          out_req_id,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int SUM_W = ID_W + 1;

    out_state_e        state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt, win_idx, cand;
    logic [SUM_W-1:0]  cand_sum;
    logic              win_found, can_accept, xfer;
    logic [1:0]        deco_arr [NUM_REQ];
    logic [31:0]       data_arr [NUM_REQ];
    logic [TAG_W-1:0]  tag_arr  [NUM_REQ];
    logic [31:0]       deco_res;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign deco_arr[g] = req_deco[2*g +: 2];
        assign data_arr[g] = req_data[32*g +: 32];
        assign tag_arr[g]  = req_tag[TAG_W*g +: TAG_W];
    end

    // Scan from rr_ptr upward; rr_ptr < NUM_REQ so one conditional subtract wraps.
    always_comb begin : arbiter
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (cand_sum >= SUM_W'(NUM_REQ)) cand_sum = cand_sum - SUM_W'(NUM_REQ);
            cand = cand_sum[ID_W-1:0];
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign can_accept = !flush && (state == OUT_EMPTY || out_ready);
    assign xfer       = win_found && can_accept && !reset;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[win_idx] = 1'b1;
    end

    operand_decorate_unit u_decorate (
        .int_float (req_int_float[win_idx]),
        .deco      (deco_arr[win_idx]),
        .data      (data_arr[win_idx]),
        .res       (deco_res)
    );

    always_comb begin : out_fsm
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        if (flush)                                state_nxt = OUT_EMPTY;
        else if (xfer)                            state_nxt = OUT_FULL;
        else if (state == OUT_FULL && out_ready)  state_nxt = OUT_EMPTY;
        if (xfer) begin
            rr_ptr_nxt = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= OUT_EMPTY;
            rr_ptr     <= '0;
            out_data   <= '0;
            out_req_id <= '0;
            out_tag    <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            if (xfer) begin
                out_data   <= deco_res;
                out_req_id <= win_idx;
                out_tag    <= tag_arr[win_idx];
            end
        end
    end

    assign out_valid = (state == OUT_FULL);

endmodule

// File: tb/tb_operand_deco_scheduler.sv
// Self-checking bench for operand_deco_scheduler: decoration vector table, directed
// arbitration/backpressure/flush/reset sequences, then randomized traffic against a reference model.
module tb_operand_deco_scheduler;

    localparam int N   = 3;
    localparam int TW  = 5;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            reset, flush, out_ready;
    logic [N-1:0]    req_valid, req_ready, req_int_float;
    logic [2*N-1:0]  req_deco;
    logic [32*N-1:0] req_data;
    logic [TW*N-1:0] req_tag;
    logic            out_valid;
    logic [31:0]     out_data;
    logic [IDW-1:0]  out_req_id;
    logic [TW-1:0]   out_tag;

    int checks = 0;
    int errors = 0;

    operand_deco_scheduler #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_int_float(req_int_float), .req_deco(req_deco),
        .req_data(req_data), .req_tag(req_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_req_id(out_req_id), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Reference model: what the consumer should see, updated once per rising edge.
    logic          m_valid = 1'b0;
    logic [31:0]   m_data  = '0;
    int            m_id    = 0;
    logic [TW-1:0] m_tag   = '0;
    int            m_ptr   = 0;

    function automatic logic [31:0] ref_deco(input logic f, input logic [1:0] d, input logic [31:0] x);
        if (!f) begin
            case (d)
                2'd0:    return x;
                2'd1:    return 32'd0 - x;
                2'd2:    return (x != 32'd0) ? 32'd1 : 32'd0;
                default: return ($signed(x) < 0) ? 32'd0 - x : x;
            endcase
        end
        case (d)
            2'd0: return x;
            2'd1: return x ^ 32'h8000_0000;
            2'd3: return x & 32'h7FFF_FFFF;
            default: begin
                if ((x & 32'h7FFF_FFFF) > 32'h7F80_0000) return 32'd0;
                if (x[31])                               return 32'd0;
                if (x > 32'h3F80_0000)                   return 32'h3F80_0000;
                return x;
            end
        endcase
    endfunction

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = model_winner();
        if (!reset && !flush && w >= 0 && (!m_valid || out_ready)) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        int w;
        logic acc;
        if (reset) begin
            m_valid = 1'b0; m_data = '0; m_id = 0; m_tag = '0; m_ptr = 0;
        end else begin
            w   = model_winner();
            acc = !flush && (!m_valid || out_ready);
            if (flush) begin
                m_valid = 1'b0;
            end else if (w >= 0 && acc) begin
                m_valid = 1'b1;
                m_data  = ref_deco(req_int_float[w], req_deco[2*w +: 2], req_data[32*w +: 32]);
                m_id    = w;
                m_tag   = req_tag[TW*w +: TW];
                m_ptr   = (w + 1) % N;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_int_float = '0; req_deco = '0; req_data = '0; req_tag = '0;
    endtask

    task automatic drive(input int i, input logic f, input logic [1:0] d,
                         input logic [31:0] x, input logic [TW-1:0] t);
        req_valid[i]          = 1'b1;
        req_int_float[i]      = f;
        req_deco[2*i +: 2]    = d;
        req_data[32*i +: 32]  = x;
        req_tag[TW*i +: TW]   = t;
    endtask

    typedef struct {
        logic        f;
        logic [1:0]  d;
        logic [31:0] x;
        logic [31:0] e;
    } vec_t;

    vec_t vecs[16];
    logic [31:0] specials[8];

    initial begin
        logic [N-1:0] er;
        logic [N-1:0] pend;

        vecs[0]  = '{1'b0, 2'b01, 32'd5,          32'hFFFF_FFFB};
        vecs[1]  = '{1'b0, 2'b11, 32'h8000_0000,  32'h8000_0000};
        vecs[2]  = '{1'b0, 2'b10, 32'd0,          32'd0};
        vecs[3]  = '{1'b0, 2'b10, 32'h0000_DEAD,  32'd1};
        vecs[4]  = '{1'b1, 2'b10, 32'hBF80_0000,  32'd0};
        vecs[5]  = '{1'b1, 2'b10, 32'h4000_0000,  32'h3F80_0000};
        vecs[6]  = '{1'b1, 2'b10, 32'h7FC0_0000,  32'd0};
        vecs[7]  = '{1'b0, 2'b00, 32'h1234_5678,  32'h1234_5678};
        vecs[8]  = '{1'b0, 2'b11, 32'hFFFF_FFFF,  32'd1};
        vecs[9]  = '{1'b1, 2'b01, 32'h7FC0_0000,  32'hFFC0_0000};
        vecs[10] = '{1'b1, 2'b11, 32'hBF80_0000,  32'h3F80_0000};
        vecs[11] = '{1'b1, 2'b10, 32'h8000_0000,  32'd0};
        vecs[12] = '{1'b1, 2'b10, 32'h3F00_0000,  32'h3F00_0000};
        vecs[13] = '{1'b1, 2'b10, 32'h7F80_0000,  32'h3F80_0000};
        vecs[14] = '{1'b1, 2'b10, 32'h3F80_0000,  32'h3F80_0000};
        vecs[15] = '{1'b0, 2'b01, 32'd0,          32'd0};

        specials = '{32'h0, 32'h8000_0000, 32'h7FC0_0000, 32'hFF80_0001,
                     32'h3F80_0000, 32'h3F80_0001, 32'h7F80_0000, 32'hFFFF_FFFF};

        // Reset state, with a request already presented
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        clear_reqs();
        drive(0, 1'b0, 2'b01, 32'd5, 5'd3);
        tick(); tick(); settle();
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_req_id", out_req_id, 0);
        check("reset_out_tag", out_tag, 0);
        check("reset_req_ready", req_ready, 0);

        // Int negate, one-cycle latency
        reset = 1'b0;
        settle();
        check("neg_req_ready", req_ready, 3'b001);
        check("neg_out_valid_before", out_valid, 0);
        tick(); clear_reqs(); settle();
        check("neg_out_valid", out_valid, 1);
        check("neg_out_data", out_data, 32'hFFFF_FFFB);
        check("neg_out_req_id", out_req_id, 0);
        check("neg_out_tag", out_tag, 3);

        // Decoration table, rotated over requesters
        for (int k = 0; k < 16; k++) begin
            clear_reqs();
            drive(k % N, vecs[k].f, vecs[k].d, vecs[k].x, TW'(k));
            settle();
            tick(); clear_reqs(); settle();
            check($sformatf("vec%0d_data", k), out_data, vecs[k].e);
            check($sformatf("vec%0d_id", k), out_req_id, k % N);
        end

        // Round robin between requesters 0 and 1
        reset = 1'b1; clear_reqs();
        tick(); tick();
        reset = 1'b0;
        drive(0, 1'b0, 2'b00, 32'hA0, 5'd10);
        drive(1, 1'b0, 2'b00, 32'hB1, 5'd11);
        for (int c = 0; c < 5; c++) begin
            settle();
            check($sformatf("rr%0d_ready", c), req_ready, (c % 2 == 0) ? 3'b001 : 3'b010);
            tick(); settle();
            check($sformatf("rr%0d_valid", c), out_valid, 1);
            check($sformatf("rr%0d_id", c), out_req_id, c % 2);
            check($sformatf("rr%0d_data", c), out_data, (c % 2 == 0) ? 32'hA0 : 32'hB1);
        end

        // Backpressure: output holds, nothing accepted
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            check($sformatf("bp%0d_ready", c), req_ready, 0);
            check($sformatf("bp%0d_valid", c), out_valid, 1);
            check($sformatf("bp%0d_id", c), out_req_id, 0);
            check($sformatf("bp%0d_data", c), out_data, 32'hA0);
            tick();
        end
        out_ready = 1'b1;
        settle();
        check("bp_release_ready", req_ready, 3'b010);
        tick(); settle();
        check("bp_release_id", out_req_id, 1);
        check("bp_release_data", out_data, 32'hB1);

        // Flush while full and stalled
        out_ready = 1'b0;
        req_valid[1] = 1'b0;
        flush = 1'b1;
        settle();
        check("flush_ready", req_ready, 0);
        tick();
        flush = 1'b0;
        settle();
        check("flush_out_valid", out_valid, 0);
        check("flush_next_ready", req_ready, 3'b001);
        tick(); settle();
        check("flush_accept_valid", out_valid, 1);
        check("flush_accept_id", out_req_id, 0);

        // Reset mid-stream with requests pending
        out_ready = 1'b1;
        req_valid[1] = 1'b1;
        reset = 1'b1;
        settle();
        check("rst_mid_ready", req_ready, 0);
        tick(); settle();
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_data", out_data, 0);
        check("rst_mid_ready2", req_ready, 0);
        reset = 1'b0;
        settle();
        check("rst_first_grant", req_ready, 3'b001);
        tick(); settle();
        check("rst_first_id", out_req_id, 0);

        // Randomized traffic against the reference model
        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    req_valid[i]         = ($urandom_range(0, 99) < 60);
                    req_int_float[i]     = $urandom_range(0, 1) != 0;
                    req_deco[2*i +: 2]   = 2'($urandom_range(0, 3));
                    req_data[32*i +: 32] = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)]
                                                                       : $urandom;
                    req_tag[TW*i +: TW]  = TW'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 6);
            reset     = ($urandom_range(0, 99) < 2);
            settle();
            er = exp_ready();
            check("rnd_req_ready", req_ready, er);
            check("rnd_out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("rnd_out_data", out_data, m_data);
                check("rnd_out_req_id", out_req_id, m_id);
                check("rnd_out_tag", out_tag, m_tag);
            end
            pend = req_valid & ~er;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
